pipe_ctrl: RTL and testbench

// Parametrised pipeline hazard and sequencing controller. It drives the per-stage stall/clr vectors that the top level currently ties off.

---
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the stage chain and the hazard/sequencing controller.
// The controller sits on the slave side; the pipeline top (or a bench) is the master.
interface pipe_ctrl_if #(
   parameter int NUM_STAGES = 5,
   parameter int REG_IDX_W  = 5,
   parameter int CNT_W      = 32
);
   logic                  i_resetn;
   logic                  i_ex_branch;
   logic                  i_ex_is_load;
   logic [REG_IDX_W-1:0]  i_ex_dest_reg;
   logic [REG_IDX_W-1:0]  i_id_rs1;
   logic [REG_IDX_W-1:0]  i_id_rs2;
   logic                  i_id_rs1_used;
   logic                  i_id_rs2_used;
   logic                  i_mem_busy;
   logic [NUM_STAGES-1:0] o_stall;
   logic [NUM_STAGES-1:0] o_clr;
   logic [1:0]            o_state;
   logic                  o_mem_timeout;
   logic [CNT_W-1:0]      o_stall_cnt;
   logic [CNT_W-1:0]      o_flush_cnt;

   modport master (
      output i_resetn, i_ex_branch, i_ex_is_load, i_ex_dest_reg, i_id_rs1, i_id_rs2,
             i_id_rs1_used, i_id_rs2_used, i_mem_busy,
      input  o_stall, o_clr, o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_resetn, i_ex_branch, i_ex_is_load, i_ex_dest_reg, i_id_rs1, i_id_rs2,
             i_id_rs1_used, i_id_rs2_used, i_mem_busy,
      output o_stall, o_clr, o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: reset clearing, load-use bubbles, branch
// flushes, memory-wait freeze with timeout, and stall/flush statistics.
module pipe_ctrl #(
   parameter int NUM_STAGES      = 5,
   parameter int REG_IDX_W       = 5,
   parameter int INIT_CLR_CYCLES = 2,
   parameter int FLUSH_STAGES    = 2,
   parameter int MEM_TIMEOUT     = 16,
   parameter int CNT_W           = 32
) (
   input  logic        clk,
   input  logic        areset,
   pipe_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_FAULT    = 2'd3
   } state_e;

   localparam int INIT_W = $clog2(INIT_CLR_CYCLES + 1);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e                state_q, state_d;
   logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                  timeout_q, timeout_d;
   logic                  lu_mask_q, lu_mask_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
   logic [NUM_STAGES-1:0] stall, clr;
   logic                  load_use, active, flush_fire, lu_fire;

   // After a bubble the EX slot holds that bubble (frozen through memory stalls),
   // so the same hazard cannot raise a second bubble.
   assign load_use = bus.i_ex_is_load && (bus.i_ex_dest_reg != '0) && !lu_mask_q &&
                     ((bus.i_id_rs1_used && (bus.i_id_rs1 == bus.i_ex_dest_reg)) ||
                      (bus.i_id_rs2_used && (bus.i_id_rs2 == bus.i_ex_dest_reg)));
   assign active   = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

   always_comb begin
      stall      = '0;
      clr        = '0;
      flush_fire = 1'b0;
      lu_fire    = 1'b0;
      case (state_q)
         ST_INIT:  clr   = '1;
         ST_FAULT: stall = '1;
         default: begin
            if (bus.i_mem_busy) begin
               stall                = {1'b0, {(NUM_STAGES-1){1'b1}}};
               clr[NUM_STAGES-1]    = 1'b1;
            end else if (bus.i_ex_branch) begin
               clr[FLUSH_STAGES-1:0] = '1;
               flush_fire            = 1'b1;
            end else if (load_use) begin
               stall[1:0] = 2'b11;
               clr[2]     = 1'b1;
               lu_fire    = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      lu_mask_d   = lu_fire || (lu_mask_q && active && bus.i_mem_busy);
      stall_cnt_d = ((|stall) && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_fire && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
      case (state_q)
         ST_INIT: begin
            if (init_cnt_q <= INIT_W'(1)) begin
               state_d    = ST_RUN;
               init_cnt_d = '0;
            end else begin
               init_cnt_d = init_cnt_q - 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.i_mem_busy) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (!bus.i_mem_busy) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_d    = ST_FAULT;
               timeout_d  = 1'b1;
               wait_cnt_d = WAIT_W'(MEM_TIMEOUT);
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      // Soft reset overrides everything, including FAULT and a pending wait.
      if (!bus.i_resetn) begin
         state_d     = ST_INIT;
         init_cnt_d  = INIT_W'(INIT_CLR_CYCLES);
         wait_cnt_d  = '0;
         timeout_d   = 1'b0;
         lu_mask_d   = 1'b0;
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= INIT_W'(INIT_CLR_CYCLES);
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         lu_mask_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         lu_mask_q   <= lu_mask_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.o_stall       = stall;
   assign bus.o_clr         = clr;
   assign bus.o_state       = state_q;
   assign bus.o_mem_timeout = timeout_q;
   assign bus.o_stall_cnt   = stall_cnt_q;
   assign bus.o_flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios followed by random traffic,
// expected values from a cycle-level behavioural model of the controller rules.
module tb_pipe_ctrl;
   localparam int NS   = 5;
   localparam int RW   = 5;
   localparam int INIT = 2;
   localparam int FL   = 2;
   localparam int MTO  = 16;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic [NS-1:0] stall;
      logic [NS-1:0] clr;
      logic [1:0]    state;
      logic          to;
      logic [CW-1:0] scnt;
      logic [CW-1:0] fcnt;
   } exp_t;

   logic clk = 1'b0;
   logic areset;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   // model state: phase (0 init,1 run,2 wait,3 fault), init cycles left, busy run length
   int m_phase, m_init_left, m_busy_run, m_scnt, m_fcnt;
   bit m_to, m_ex_bubble;

   pipe_ctrl_if #(.NUM_STAGES(NS), .REG_IDX_W(RW), .CNT_W(CW)) bus ();

   pipe_ctrl #(
      .NUM_STAGES(NS), .REG_IDX_W(RW), .INIT_CLR_CYCLES(INIT),
      .FLUSH_STAGES(FL), .MEM_TIMEOUT(MTO), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .areset(areset),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_phase = 0; m_init_left = INIT; m_busy_run = 0;
      m_scnt = 0; m_fcnt = 0; m_to = 0; m_ex_bubble = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at posedge+2, push the expected response, advance the model.
   task automatic step(input bit ar, input bit rn, input bit br, input bit ld,
                       input logic [RW-1:0] dst, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                       input bit u1, input bit u2, input bit mb);
      exp_t e;
      bit hazard, flush, bubble;
      areset = ar;
      bus.i_resetn = rn; bus.i_ex_branch = br; bus.i_ex_is_load = ld;
      bus.i_ex_dest_reg = dst; bus.i_id_rs1 = r1; bus.i_id_rs2 = r2;
      bus.i_id_rs1_used = u1; bus.i_id_rs2_used = u2; bus.i_mem_busy = mb;
      if (ar) model_reset();
      hazard = ld && (dst != 0) && ((u1 && r1 == dst) || (u2 && r2 == dst)) && !m_ex_bubble;
      e.stall = '0; e.clr = '0; flush = 0; bubble = 0;
      if (m_phase == 0) e.clr = '1;
      else if (m_phase == 3) e.stall = '1;
      else if (mb) begin
         for (int i = 0; i < NS - 1; i++) e.stall[i] = 1'b1;
         e.clr[NS-1] = 1'b1;
      end else if (br) begin
         for (int i = 0; i < FL; i++) e.clr[i] = 1'b1;
         flush = 1;
      end else if (hazard) begin
         e.stall[0] = 1'b1; e.stall[1] = 1'b1; e.clr[2] = 1'b1;
         bubble = 1;
      end
      e.state = 2'(m_phase); e.to = m_to;
      e.scnt = CW'(m_scnt); e.fcnt = CW'(m_fcnt);
      sb.push_back(e);
      if (!ar) begin
         if (!rn) model_reset();
         else begin
            if (e.stall != 0 && m_scnt < CMAX) m_scnt++;
            if (flush && m_fcnt < CMAX) m_fcnt++;
            m_ex_bubble = bubble || (m_ex_bubble && mb && (m_phase == 1 || m_phase == 2));
            case (m_phase)
               0: begin m_init_left--; if (m_init_left == 0) m_phase = 1; end
               1: if (mb) begin m_phase = 2; m_busy_run = 1; end
               2: if (!mb) m_phase = 1;
                  else begin
                     m_busy_run++;
                     if (m_busy_run >= MTO) begin m_phase = 3; m_to = 1; end
                  end
               default: ;
            endcase
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic busy(input int n, input bit br);
      for (int i = 0; i < n; i++) step(0, 1, br, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Monitor: the DUT presents a response every cycle; compare mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("o_stall", 32'(bus.o_stall), 32'(e.stall));
            chk("o_clr", 32'(bus.o_clr), 32'(e.clr));
            chk("o_state", 32'(bus.o_state), 32'(e.state));
            chk("o_mem_timeout", 32'(bus.o_mem_timeout), 32'(e.to));
            chk("o_stall_cnt", 32'(bus.o_stall_cnt), 32'(e.scnt));
            chk("o_flush_cnt", 32'(bus.o_flush_cnt), 32'(e.fcnt));
         end
      end
   end

   initial begin
      int burst;
      bit ar, rn, br, ld, u1, u2, mb;
      logic [RW-1:0] dst, r1, r2;
      areset = 1'b1;
      bus.i_resetn = 1'b1; bus.i_ex_branch = 0; bus.i_ex_is_load = 0;
      bus.i_ex_dest_reg = 0; bus.i_id_rs1 = 0; bus.i_id_rs2 = 0;
      bus.i_id_rs1_used = 0; bus.i_id_rs2_used = 0; bus.i_mem_busy = 0;
      model_reset();
      @(posedge clk);
      #2;
      // reset state, then release through INIT
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      // load-use on x5 via rs1, then via rs2, then x0 (no stall)
      step(0, 1, 0, 1, 5, 5, 0, 1, 0, 0); idle(1);
      step(0, 1, 0, 1, 7, 1, 7, 0, 1, 0); idle(1);
      step(0, 1, 0, 1, 0, 0, 0, 1, 1, 0); idle(1);
      // unused source matching dest: no stall
      step(0, 1, 0, 1, 9, 9, 9, 0, 0, 0); idle(1);
      // hazard held two cycles yields one bubble only
      step(0, 1, 0, 1, 3, 3, 0, 1, 0, 0); step(0, 1, 0, 1, 3, 3, 0, 1, 0, 0); idle(1);
      // branch pulse, branch over load-use priority
      step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); idle(1);
      step(0, 1, 1, 1, 4, 4, 0, 1, 0, 0); idle(1);
      // memory wait of 3, then branch held across a wait of 2 and released
      busy(3, 0); idle(2);
      busy(2, 1); step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); idle(1);
      // load-use pending across a memory wait
      busy(2, 0); step(0, 1, 0, 1, 6, 0, 6, 0, 1, 0); idle(1);
      // timeout into FAULT, soft reset out of it
      busy(MTO, 0); busy(2, 0); idle(2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); idle(4);
      // one short of timeout recovers
      busy(MTO - 1, 0); idle(2);
      // soft reset mid-wait, async reset mid-run
      busy(3, 0); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); idle(4);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); idle(4);
      // stall counter saturation while in FAULT
      busy(MTO, 0); idle(CMAX + 10);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); idle(3);
      // random traffic
      burst = 0;
      for (int n = 0; n < 4000; n++) begin
         if (burst == 0 && $urandom_range(0, 9) == 0)
            burst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(1, 5));
         mb = (burst > 0);
         if (burst > 0) burst--;
         ar  = ($urandom_range(0, 499) == 0);
         rn  = ($urandom_range(0, 199) != 0);
         br  = ($urandom_range(0, 5) == 0);
         ld  = ($urandom_range(0, 1) == 0);
         u1  = ($urandom_range(0, 2) != 0);
         u2  = ($urandom_range(0, 2) != 0);
         dst = RW'($urandom_range(0, 3));
         r1  = RW'($urandom_range(0, 3));
         r2  = RW'($urandom_range(0, 3));
         step(ar, rn, br, ld, dst, r1, r2, u1, u2, mb);
      end
      idle(2);
      #10;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
